// File: rtl/hl_seq_pkg.sv
// Shared types and constants for the high/low register write sequencer.
package hl_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_HI = 2'd1,
        WR_LO = 2'd2,
        CLR   = 2'd3
    } state_t;

    // Bit positions inside a requester's 2-bit half select
    localparam int HSEL_HI = 1;
    localparam int HSEL_LO = 0;

    typedef logic req_id_t;

endpackage

// File: rtl/hl_write_sequencer_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the winner on every advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] elig,
    input  logic       advance,
    output logic [1:0] win
);

    // ptr=0 favours requester 0, ptr=1 favours requester 1
    logic ptr;

    always_comb begin
        win = elig;
        if (elig == 2'b11) begin
            win = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (advance && (win != 2'b00)) begin
            ptr <= win[0];
        end
    end

endmodule

// File: rtl/hl_write_sequencer.sv
// Sequences full/half word writes to a split high/low register over one byte lane.
// Optional per-requester grant counters are enabled with HL_SEQ_STATS_EN.
module hl_write_sequencer
    import hl_seq_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req,
    input  logic [1:0]     hsel0,
    input  logic [1:0]     hsel1,
    input  logic [N-1:0]   wdata0,
    input  logic [N-1:0]   wdata1,
    input  logic           clr_req,
    output logic [1:0]     gnt,
    output logic           clr_ack,
    output logic           done,
    output logic           busy,
    output logic           owner,
    output logic [N/2-1:0] lane,
    output logic           loadh,
    output logic           loadl,
    output logic           reg_clear
`ifdef HL_SEQ_STATS_EN
    ,
    output logic [7:0]     gcnt0,
    output logic [7:0]     gcnt1
`endif
);

    localparam int H = N / 2;

    state_t     state_q, state_d;
    logic [1:0] elig, win;
    logic       advance;
    logic [1:0] sel_hsel;
    logic [N-1:0] sel_data;
    logic [N-1:0] cap_data_p1;
    logic       cap_lo_p1;
    logic [1:0] gnt_q;
    req_id_t    owner_q;
    logic       clr_ack_c, done_c, loadh_c, loadl_c;
    logic [H-1:0] lane_c;

    assign elig[0]  = req[0] && (hsel0 != 2'b00);
    assign elig[1]  = req[1] && (hsel1 != 2'b00);
    assign sel_hsel = win[1] ? hsel1 : hsel0;
    assign sel_data = win[1] ? wdata1 : wdata0;
    assign advance  = (state_q == IDLE) && !clr_req && (win != 2'b00);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .elig    (elig),
        .advance (advance),
        .win     (win)
    );

    always_comb begin
        state_d   = state_q;
        clr_ack_c = 1'b0;
        done_c    = 1'b0;
        loadh_c   = 1'b0;
        loadl_c   = 1'b0;
        lane_c    = '0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLR;
                end else if (win != 2'b00) begin
                    state_d = sel_hsel[HSEL_HI] ? WR_HI : WR_LO;
                end
            end
            WR_HI: begin
                loadh_c = 1'b1;
                lane_c  = cap_data_p1[N-1:H];
                if (cap_lo_p1) begin
                    state_d = WR_LO;
                end else begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_LO: begin
                loadl_c = 1'b1;
                lane_c  = cap_data_p1[H-1:0];
                done_c  = 1'b1;
                state_d = IDLE;
            end
            CLR: begin
                clr_ack_c = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    // A reset cycle abandons any in-flight write: no load, no done
    assign gnt       = reset ? 2'b00 : gnt_q;
    assign clr_ack   = clr_ack_c && !reset;
    assign done      = done_c && !reset;
    assign loadh     = loadh_c && !reset;
    assign loadl     = loadl_c && !reset;
    assign lane      = reset ? '0 : lane_c;
    assign busy      = (state_q != IDLE) && !reset;
    assign owner     = owner_q;
    assign reg_clear = reset || (state_q == CLR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= advance ? win : 2'b00;
            if (advance) begin
                owner_q <= win[1];
            end
        end
    end

    // Capture stage: winner's word and low-half flag held for the write states
    always_ff @(posedge clk) begin
        if (advance) begin
            cap_data_p1 <= sel_data;
            cap_lo_p1   <= sel_hsel[HSEL_LO];
        end
    end

`ifdef HL_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            gcnt0 <= 8'd0;
            gcnt1 <= 8'd0;
        end else begin
            if (gnt_q[0] && (gcnt0 != 8'hFF)) gcnt0 <= gcnt0 + 8'd1;
            if (gnt_q[1] && (gcnt1 != 8'hFF)) gcnt1 <= gcnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hl_write_sequencer.sv
// Directed self-checking bench for hl_write_sequencer (stats ports when HL_SEQ_STATS_EN).
module tb_hl_write_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  hsel0 = 2'b00;
    logic [1:0]  hsel1 = 2'b00;
    logic [15:0] wdata0 = 16'h0000;
    logic [15:0] wdata1 = 16'h0000;
    logic        clr_req = 1'b0;
    logic [1:0]  gnt;
    logic        clr_ack, done, busy, owner, loadh, loadl, reg_clear;
    logic [7:0]  lane;
`ifdef HL_SEQ_STATS_EN
    logic [7:0]  gcnt0, gcnt1;
`endif

    int assertions = 0;
    int failures   = 0;

    // Model of the register_hl instance fed by the sequencer outputs
    logic [15:0] regm;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_clear) begin
            regm <= 16'h0000;
        end else begin
            if (loadh) regm[15:8] <= lane;
            if (loadl) regm[7:0]  <= lane;
        end
    end

    hl_write_sequencer #(.N(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .hsel0     (hsel0),
        .hsel1     (hsel1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .clr_req   (clr_req),
        .gnt       (gnt),
        .clr_ack   (clr_ack),
        .done      (done),
        .busy      (busy),
        .owner     (owner),
        .lane      (lane),
        .loadh     (loadh),
        .loadl     (loadl),
        .reg_clear (reg_clear)
`ifdef HL_SEQ_STATS_EN
        ,
        .gcnt0     (gcnt0),
        .gcnt1     (gcnt1)
`endif
    );

    task automatic do_reset();
        reset = 1'b1; req = 2'b00; hsel0 = 2'b00; hsel1 = 2'b00;
        wdata0 = 16'h0; wdata1 = 16'h0; clr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        assertions++;
        if ({gnt, clr_ack, done, busy, owner, lane, loadh, loadl} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", {gnt, clr_ack, done, busy, owner, lane, loadh, loadl});
        end
        assertions++;
        if (reg_clear !== 1'b1) begin
            failures++;
            $display("FAIL reset_reg_clear: got %b required 1", reg_clear);
        end
        reset = 1'b0;
        @(negedge clk);
        assertions++;
        if (reg_clear !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: reg_clear=%b busy=%b required 0 0", reg_clear, busy);
        end
    endtask

    task automatic test_full_write();
        do_reset();
        req = 2'b01; hsel0 = 2'b11; wdata0 = 16'hA55A;
        @(negedge clk);
        assertions++;
        if (gnt !== 2'b01 || loadh !== 1'b1 || loadl !== 1'b0 || lane !== 8'hA5 || done !== 1'b0) begin
            failures++;
            $display("FAIL full_hi: gnt=%b loadh=%b loadl=%b lane=%h done=%b required 01 1 0 a5 0", gnt, loadh, loadl, lane, done);
        end
        req = 2'b00; wdata0 = 16'hFFFF;
        @(negedge clk);
        assertions++;
        if (gnt !== 2'b00 || loadh !== 1'b0 || loadl !== 1'b1 || lane !== 8'h5A || done !== 1'b1) begin
            failures++;
            $display("FAIL full_lo: gnt=%b loadh=%b loadl=%b lane=%h done=%b required 00 0 1 5a 1", gnt, loadh, loadl, lane, done);
        end
        @(negedge clk);
        assertions++;
        if (regm !== 16'hA55A || busy !== 1'b0 || lane !== 8'h00) begin
            failures++;
            $display("FAIL full_result: reg=%h busy=%b lane=%h required a55a 0 00", regm, busy, lane);
        end
    endtask

    task automatic test_contention();
        int t;
        do_reset();
        req = 2'b11; hsel0 = 2'b11; hsel1 = 2'b11; wdata0 = 16'h1111; wdata1 = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (gnt === 2'b00 && t < 8) begin
                @(negedge clk);
                t++;
            end
            assertions++;
            if (gnt !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL contention_grant%0d: got %b required %b", k, gnt, (k % 2 == 1) ? 2'b10 : 2'b01);
            end
            @(negedge clk);
            @(negedge clk);
            assertions++;
            if (busy !== 1'b0 || gnt !== 2'b00) begin
                failures++;
                $display("FAIL contention_idle_gap%0d: busy=%b gnt=%b required 0 00", k, busy, gnt);
            end
        end
        req = 2'b00;
        assertions++;
        if (regm !== 16'h2222 || owner !== 1'b1) begin
            failures++;
            $display("FAIL contention_last: reg=%h owner=%b required 2222 1", regm, owner);
        end
    endtask

    task automatic test_half_and_mask();
        int bad;
        do_reset();
        req = 2'b10; hsel1 = 2'b01; wdata1 = 16'h1234;
        @(negedge clk);
        assertions++;
        if (gnt !== 2'b10 || loadl !== 1'b1 || loadh !== 1'b0 || lane !== 8'h34 || done !== 1'b1 || owner !== 1'b1) begin
            failures++;
            $display("FAIL half_lo: gnt=%b loadl=%b loadh=%b lane=%h done=%b owner=%b required 10 1 0 34 1 1",
                     gnt, loadl, loadh, lane, done, owner);
        end
        req = 2'b00;
        @(negedge clk);
        assertions++;
        if (regm !== 16'h0034 || busy !== 1'b0) begin
            failures++;
            $display("FAIL half_result: reg=%h busy=%b required 0034 0", regm, busy);
        end
        req = 2'b01; hsel0 = 2'b00; wdata0 = 16'hFFFF;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (gnt !== 2'b00 || busy !== 1'b0) bad++;
        end
        assertions++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL mask_hsel00: %0d cycles granted or busy, required 0", bad);
        end
        req = 2'b00;
    endtask

    task automatic test_clear_priority();
        do_reset();
        clr_req = 1'b1; req = 2'b01; hsel0 = 2'b11; wdata0 = 16'hBEEF;
        @(negedge clk);
        assertions++;
        if (clr_ack !== 1'b1 || reg_clear !== 1'b1 || gnt !== 2'b00) begin
            failures++;
            $display("FAIL clr_first: clr_ack=%b reg_clear=%b gnt=%b required 1 1 00", clr_ack, reg_clear, gnt);
        end
        clr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        assertions++;
        if (gnt !== 2'b01 || loadh !== 1'b1) begin
            failures++;
            $display("FAIL clr_then_write: gnt=%b loadh=%b required 01 1", gnt, loadh);
        end
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        assertions++;
        if (regm !== 16'hBEEF) begin
            failures++;
            $display("FAIL clr_then_write_result: reg=%h required beef", regm);
        end
    endtask

    task automatic test_clear_deferral();
        do_reset();
        req = 2'b01; hsel0 = 2'b11; wdata0 = 16'h0F0F;
        @(negedge clk);
        clr_req = 1'b1; req = 2'b00;
        @(negedge clk);
        assertions++;
        if (loadl !== 1'b1 || done !== 1'b1 || clr_ack !== 1'b0) begin
            failures++;
            $display("FAIL defer_lo_completes: loadl=%b done=%b clr_ack=%b required 1 1 0", loadl, done, clr_ack);
        end
        @(negedge clk);
        assertions++;
        if (regm !== 16'h0F0F || busy !== 1'b0) begin
            failures++;
            $display("FAIL defer_written: reg=%h busy=%b required 0f0f 0", regm, busy);
        end
        @(negedge clk);
        assertions++;
        if (clr_ack !== 1'b1 || reg_clear !== 1'b1) begin
            failures++;
            $display("FAIL defer_clear: clr_ack=%b reg_clear=%b required 1 1", clr_ack, reg_clear);
        end
        clr_req = 1'b0;
        @(negedge clk);
        assertions++;
        if (regm !== 16'h0000 || clr_ack !== 1'b0) begin
            failures++;
            $display("FAIL defer_cleared: reg=%h clr_ack=%b required 0000 0", regm, clr_ack);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        req = 2'b01; hsel0 = 2'b11; wdata0 = 16'hCAFE;
        @(negedge clk);
        reset = 1'b1; req = 2'b00;
        @(negedge clk);
        assertions++;
        if (done !== 1'b0 || busy !== 1'b0 || loadl !== 1'b0 || reg_clear !== 1'b1 || regm !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_write: done=%b busy=%b loadl=%b reg_clear=%b reg=%h required 0 0 0 1 0000",
                     done, busy, loadl, reg_clear, regm);
        end
        reset = 1'b0;
        @(negedge clk);
        assertions++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_write_after: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

`ifdef HL_SEQ_STATS_EN
    task automatic test_stats();
        int seen;
        int t;
        do_reset();
        req = 2'b01; hsel0 = 2'b01; wdata0 = 16'h0001;
        seen = 0; t = 0;
        while (seen < 300 && t < 2000) begin
            @(negedge clk);
            t++;
            if (gnt[0] === 1'b1) begin
                seen++;
                if (seen == 300) req = 2'b00;
            end
        end
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        assertions++;
        if (seen !== 300 || gcnt0 !== 8'd255 || gcnt1 !== 8'd0) begin
            failures++;
            $display("FAIL stats_saturate: grants=%0d gcnt0=%0d gcnt1=%0d required 300 255 0", seen, gcnt0, gcnt1);
        end
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        @(negedge clk);
        assertions++;
        if (gcnt0 !== 8'd255) begin
            failures++;
            $display("FAIL stats_after_clear: gcnt0=%0d required 255", gcnt0);
        end
        do_reset();
        @(negedge clk);
        assertions++;
        if (gcnt0 !== 8'd0 || gcnt1 !== 8'd0) begin
            failures++;
            $display("FAIL stats_reset: gcnt0=%0d gcnt1=%0d required 0 0", gcnt0, gcnt1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_write();
        test_contention();
        test_half_and_mask();
        test_clear_priority();
        test_clear_deferral();
        test_reset_mid_write();
`ifdef HL_SEQ_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/hl_write_sequencer.md
Name: hl_write_sequencer

Overview:
- Arbitrates two requesters plus a clear requester for one shared split high/low register (`register_hl`, N=16).
- The register is driven through a single N/2-bit byte lane, so a full-word write is sequenced as two cycles: high half, then low half.
- Generates the register's `inh`/`inl`, `loadh`, `loadl` and `clear` controls.
- Sits between the datapath clients and the register instance.

Parameters:
- N, 16, register width; must be even; byte lane is N/2.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  2  request level per requester (bit i = requester i)
- hsel0  in  2  requester 0 half select: [1]=high, [0]=low
- hsel1  in  2  requester 1 half select
- wdata0  in  N  requester 0 write word
- wdata1  in  N  requester 1 write word
- clr_req  in  1  request to clear the register
- gnt  out  2  one-hot, one-cycle grant pulse
- clr_ack  out  1  one-cycle pulse while the clear is issued
- done  out  1  high during the final load cycle of a granted write
- busy  out  1  high in any state except IDLE
- owner  out  1  id of the last granted requester
- lane  out  N/2  byte lane; drives both inh and inl of the register
- loadh  out  1  register high-half load
- loadl  out  1  register low-half load
- reg_clear  out  1  register clear; equals reset OR (state==CLR)

Behaviour:
- States: IDLE, WR_HI, WR_LO, CLR.
- Reset (sync) values:
  - state=IDLE; gnt=0, clr_ack=0, done=0, busy=0.
  - lane=0, loadh=0, loadl=0, owner=0.
  - RR pointer favours requester 0.
  - reg_clear=1 while reset is high.
- Eligibility: requester i is eligible iff req[i]=1 and hsel_i!=00. hsel=00 is never granted.
- IDLE priority, highest first:
  - clr_req=1 → CLR.
  - Else if any requester is eligible, the round-robin winner is chosen. Its wdata/hsel are captured into internal registers at that edge.
  - Next state: WR_HI if hsel[1]=1, else WR_LO.
  - gnt[winner]=1 for exactly the first cycle of that state.
  - owner is updated to the winner.
- Round robin: after a grant to i, the pointer favours 1-i. If only one requester is eligible, it wins regardless of the pointer.
- WR_HI:
  - lane = captured[N-1:N/2]; loadh=1.
  - Next state is WR_LO if captured hsel[0]=1. Otherwise done=1 in this cycle and next state is IDLE.
- WR_LO:
  - lane = captured[N/2-1:0]; loadl=1; done=1.
  - Next state is IDLE.
- CLR: reg_clear=1, clr_ack=1 for one cycle; next state IDLE.
- loadh and loadl are never asserted in the same cycle. lane=0 whenever no load is active.
- Latency for a full word: request seen in IDLE at cycle 0 → WR_HI at cycle 1 → WR_LO at cycle 2 → register holds the word after the cycle-2 edge.
- At least one IDLE cycle separates consecutive transactions.
- Requester handshake:
  - Requester holds req and data until it sees gnt.
  - Data may change from the gnt cycle onward.
  - If req is still high in the cycle after done, it is treated as a new request.
- clr_req during a write is deferred until the write completes. A write is never aborted.
- clr_req stays pending while high; the clearer drops it after clr_ack.
- Reset mid-write: the transaction is abandoned with no done pulse, and the register is cleared via reg_clear.

Optional Feature:
- Macro `HL_SEQ_STATS_EN`.
- Defined:
  - Adds output ports gcnt0 and gcnt1 (8 bits each): per-requester saturating grant counters.
  - A counter increments on its gnt pulse and holds at 255.
  - Both counters reset to 0 on reset.
  - Counters are unaffected by CLR.
- Undefined: these ports and the counters do not exist. All other behaviour is identical.

Decomposition:
- Package hl_seq_pkg holds:
  - state enum (IDLE, WR_HI, WR_LO, CLR);
  - HSEL_HI and HSEL_LO bit-index constants;
  - requester-id typedef.
- Sub-module rr_arb2: a 2-way round-robin arbiter.
  - Inputs: clk, reset, elig[1:0], advance.
  - Output: one-hot win[1:0].
  - Owns the pointer register.

Test Plan:
- Reset: assert reset 2 cycles → all outputs 0 except reg_clear=1; release → reg_clear=0, busy=0.
- Full write: req=01, hsel0=11, wdata0=16'hA55A:
  - gnt=01 with loadh=1, lane=8'hA5;
  - next cycle loadl=1, lane=8'h5A, done=1;
  - register reads 16'hA55A.
- Contention: req=11 held, both hsel=11 → grant order 0,1,0,1 over four transactions, each separated by one IDLE cycle.
- Half writes and masking:
  - hsel1=01, wdata1=16'h1234 → only loadl with lane=8'h34; done is in that cycle.
  - hsel0=00 with req0=1 → never granted.
- Clear priority and deferral:
  - clr_req and req0 rise in the same IDLE cycle → CLR first (clr_ack), then the requester 0 write.
  - clr_req raised during WR_HI → WR_LO completes, then CLR.
- With `HL_SEQ_STATS_EN`: 300 grants to requester 0 → gcnt0=255, gcnt1 unchanged. Reset mid-WR_HI → no done pulse, state IDLE.
